// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter sequencer.
//  - state_e : sequencer FSM states (BOOT, RUN, HALT)
//  - src_e   : next-PC source selected by the priority mux
//  - INST_BYTES : size of one instruction in bytes (sequential PC step)
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_JR     = 3'd3,
    SRC_RET    = 3'd4,
    SRC_ERET   = 3'd5,
    SRC_TRAP   = 3'd6
  } src_e;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack used by pc_sequencer when PC_RAS_EN
// is defined.
//  Ports:
//   clk, rst    clock and synchronous active-high reset
//   push        write push_data as the new top entry
//   pop         discard the top entry (ignored when empty)
//   push_data   address to push
//   top         current top entry (meaningful only when !empty)
//   empty       no valid entries
//  push and pop together replace the top entry. A push when full overwrites
//  the oldest entry and the count saturates at DEPTH.
module pc_ras #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic            pop_ok;

  assign pop_ok = pop && (cnt_q != '0);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push && pop_ok) begin
      // Pop then push collapses to an in-place overwrite of the top entry.
      wr_en = 1'b1;
    end else if (push) begin
      // The pointer wraps naturally (DEPTH is a power of 2), so a full
      // stack overwrites its oldest entry.
      ptr_d  = ptr_q + PW'(1);
      wr_idx = ptr_d;
      wr_en  = 1'b1;
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop_ok) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the storage array is not reset; the count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

  assign top   = mem_q[ptr_q];
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC generation for the single-cycle core.
//  Chooses the next fetch address from sequential, branch, jump, register
//  jump, return, trap and exception-return sources with a fixed priority,
//  and handles stall, halt/resume and trap vectoring with EPC capture.
//  Optional feature macro: PC_RAS_EN (adds the pc_ras return-address stack;
//  without it call is ignored, ret acts as jr and ras_empty is tied 1).
//  Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               freeze every register this cycle
//   halt / resume       enter / leave HALT
//   branch_taken, branch_imm   PC-relative branch (word offset, sign-extended)
//   jump, jump_idx      region-absolute jump
//   jr, jr_target       register jump (misaligned target traps)
//   call, ret           return-address stack push / pop
//   trap, eret          exception entry / return
//   pc, pc_valid        fetch address and live-fetch flag (state RUN)
//   epc                 PC of the trapping instruction
//   ras_empty           return-address stack empty
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0080),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  input  logic            branch_taken,
  input  logic [15:0]     branch_imm,
  input  logic            jump,
  input  logic [25:0]     jump_idx,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_target,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  input  logic            eret,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            ras_empty
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            pc_valid_q, pc_valid_d;
  logic [XLEN-1:0] pc4, br_off, jump_tgt;
  logic            run_go;
  src_e            src;

  assign pc4      = pc_q + XLEN'(INST_BYTES);
  assign br_off   = {{(XLEN-18){branch_imm[15]}}, branch_imm, 2'b00};
  assign jump_tgt = {pc4[XLEN-1:28], jump_idx, 2'b00};
  assign run_go   = (state_q == RUN) && !stall;

`ifdef PC_RAS_EN
  logic [XLEN-1:0] ras_top;
  logic            ras_push, ras_pop;

  assign ras_pop  = run_go && (src == SRC_RET);
  // A call is a linking jump; paired with a taken return it replaces the top.
  assign ras_push = run_go && call && ((src == SRC_JUMP) || (src == SRC_RET));

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc4),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  logic unused_call;
  assign unused_call = call;
  assign ras_empty   = 1'b1;
`endif

  // Fixed-priority source select. A misaligned register target becomes a
  // trap; a return with nothing stacked falls back to the register target.
  always_comb begin
    src = SRC_SEQ;
    if (trap)                              src = SRC_TRAP;
    else if (eret)                         src = SRC_ERET;
`ifdef PC_RAS_EN
    else if (ret && !ras_empty)            src = SRC_RET;
`endif
    else if (jr || ret)                    src = (jr_target[1:0] != 2'b00) ? SRC_TRAP : SRC_JR;
    else if (jump)                         src = SRC_JUMP;
    else if (branch_taken)                 src = SRC_BRANCH;
  end

  // NOTE: combinational next-state logic uses blocking '=', the state registers below use non-blocking '<='.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    if (!stall) begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          case (src)
            SRC_TRAP: begin
              pc_d  = TRAP_VEC;
              epc_d = pc_q;
            end
            SRC_ERET:   pc_d = epc_q;
`ifdef PC_RAS_EN
            SRC_RET:    pc_d = ras_top;
`endif
            SRC_JR:     pc_d = jr_target;
            SRC_JUMP:   pc_d = jump_tgt;
            SRC_BRANCH: pc_d = pc4 + br_off;
            default:    pc_d = pc4;
          endcase
          // The redirect above still lands on this edge before halting.
          if (halt) state_d = HALT;
        end
        HALT: if (resume) state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  assign pc_valid_d = (state_d == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      pc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign pc_valid = pc_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic, compared through a scoreboard queue against a behavioural model.
// Build with +define+PC_RAS_EN to exercise the return-address stack.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0080;
  localparam int          RAS_DEPTH = 4;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        halt;
    logic        resume;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_idx;
    logic        jr;
    logic [31:0] jr_target;
    logic        call;
    logic        ret;
    logic        trap;
    logic        eret;
  } stim_t;

  typedef struct {
    int          due;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        valid;
    logic        empty;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, halt = 1'b0, resume = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_imm = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_idx = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic        call = 1'b0, ret = 1'b0, trap = 1'b0, eret = 1'b0;
  logic [31:0] pc, epc;
  logic        pc_valid, ras_empty;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  exp_t exp_q[$];

  // Behavioural reference state.
  logic [31:0] m_pc, m_epc;
  int          m_mode;  // 0 boot, 1 run, 2 halted
  logic [31:0] m_stack[$];

  pc_sequencer #(
    .XLEN      (32),
    .RESET_VEC (RESET_VEC),
    .TRAP_VEC  (TRAP_VEC),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .halt         (halt),
    .resume       (resume),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_idx     (jump_idx),
    .jr           (jr),
    .jr_target    (jr_target),
    .call         (call),
    .ret          (ret),
    .trap         (trap),
    .eret         (eret),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .epc          (epc),
    .ras_empty    (ras_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Reference model: one clock edge of the sequencer, straight from the rules.
  task automatic model_step(input stim_t s);
    logic [31:0] seq, nxt;
    logic        took_jump, popped;
    if (s.rst) begin
      m_pc = RESET_VEC;
      m_epc = 32'h0;
      m_mode = 0;
      m_stack.delete();
      return;
    end
    if (s.stall) return;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      if (s.resume) m_mode = 1;
    end else begin
      seq = m_pc + 32'd4;
      nxt = seq;
      took_jump = 1'b0;
      popped = 1'b0;
      if (s.trap) begin
        nxt = TRAP_VEC; m_epc = m_pc;
      end else if (s.eret) begin
        nxt = m_epc;
`ifdef PC_RAS_EN
      end else if (s.ret && m_stack.size() > 0) begin
        nxt = m_stack.pop_back(); popped = 1'b1;
`endif
      end else if (s.jr || s.ret) begin
        if (s.jr_target % 4 != 0) begin
          nxt = TRAP_VEC; m_epc = m_pc;
        end else nxt = s.jr_target;
      end else if (s.jump) begin
        nxt = (seq & 32'hF000_0000) | (32'(s.jump_idx) * 4);
        took_jump = 1'b1;
      end else if (s.branch_taken) begin
        nxt = seq + 32'($signed(s.branch_imm)) * 4;
      end
`ifdef PC_RAS_EN
      if (s.call && (took_jump || popped)) begin
        m_stack.push_back(seq);
        if (m_stack.size() > RAS_DEPTH) void'(m_stack.pop_front());
      end
`else
      if (took_jump || popped) begin end
`endif
      m_pc = nxt;
      if (s.halt) m_mode = 2;
    end
  endtask

  // Apply one cycle of stimulus and queue the response expected after the edge.
  task automatic drive(input stim_t s, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; stall = s.stall; halt = s.halt; resume = s.resume;
    branch_taken = s.branch_taken; branch_imm = s.branch_imm;
    jump = s.jump; jump_idx = s.jump_idx; jr = s.jr; jr_target = s.jr_target;
    call = s.call; ret = s.ret; trap = s.trap; eret = s.eret;
    model_step(s);
    e.due = cyc + 1;
    e.pc = m_pc;
    e.epc = m_epc;
    e.valid = (m_mode == 1);
    e.empty = (m_stack.size() == 0);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic go_jump(input logic [31:0] target, input string tag);
    stim_t s;
    s = idle();
    s.jump = 1'b1;
    s.jump_idx = target[27:2];
    drive(s, tag);
  endtask

  // Monitor: compares the DUT against each queued expectation once it is due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check({e.tag, " pc"}, pc, e.pc);
        check({e.tag, " epc"}, epc, e.epc);
        check({e.tag, " pc_valid"}, 32'(pc_valid), 32'(e.valid));
        check({e.tag, " ras_empty"}, 32'(ras_empty), 32'(e.empty));
      end
    end
  end

  initial begin
    stim_t s;
    // Reset and free-run from the reset vector.
    s = idle(); s.rst = 1'b1;
    drive(s, "reset");
    drive(s, "reset");
    for (int i = 0; i < 5; i++) drive(idle(), "boot_run");

    // Branch backward by one word, then forward.
    go_jump(32'h100, "to_100");
    s = idle(); s.branch_taken = 1'b1; s.branch_imm = 16'hFFFF;
    drive(s, "branch_back");
    s.branch_imm = 16'h0010;
    drive(s, "branch_fwd");

    // Trap beats a simultaneous jump, eret returns.
    go_jump(32'h200, "to_200");
    s = idle(); s.trap = 1'b1; s.jump = 1'b1; s.jump_idx = 26'h123;
    drive(s, "trap_jump");
    s = idle(); s.eret = 1'b1;
    drive(s, "eret");

    // Misaligned register jump traps; trap held under stall is dropped.
    s = idle(); s.jr = 1'b1; s.jr_target = 32'h302;
    drive(s, "jr_misalign");
    s = idle(); s.stall = 1'b1; s.trap = 1'b1;
    for (int i = 0; i < 3; i++) drive(s, "stall_trap");
    s.stall = 1'b0;
    drive(s, "trap_after_stall");

    // Wrap at the top of the address space, then halt with a jump.
    s = idle(); s.jr = 1'b1; s.jr_target = 32'hFFFF_FFFC;
    drive(s, "to_top");
    drive(idle(), "wrap");
    go_jump(32'h40, "to_40");
    s = idle(); s.halt = 1'b1; s.jump = 1'b1; s.jump_idx = 26'h80;
    drive(s, "halt_jump");
    s = idle(); s.trap = 1'b1;
    for (int i = 0; i < 3; i++) drive(s, "halted_trap");
    s = idle(); s.resume = 1'b1;
    drive(s, "resume");
    drive(idle(), "after_resume");

`ifdef PC_RAS_EN
    // Five calls into a four-deep stack, then five returns.
    go_jump(32'h10, "to_10");
    for (int i = 1; i <= 5; i++) begin
      s = idle(); s.call = 1'b1; s.jump = 1'b1;
      s.jump_idx = (i == 5) ? 26'h40 : 26'((i + 1) * 4);
      drive(s, "call");
    end
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.ret = 1'b1; s.jr_target = 32'h600;
      drive(s, "ret");
    end
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.rst          = ($urandom_range(0, 199) == 0);
      s.stall        = ($urandom_range(0, 9) == 0);
      s.halt         = ($urandom_range(0, 24) == 0);
      s.resume       = ($urandom_range(0, 3) == 0);
      s.trap         = ($urandom_range(0, 29) == 0);
      s.eret         = ($urandom_range(0, 19) == 0);
      s.jr           = ($urandom_range(0, 9) == 0);
      s.jr_target    = $urandom;
      if ($urandom_range(0, 3) != 0) s.jr_target[1:0] = 2'b00;
      s.jump         = ($urandom_range(0, 7) == 0);
      s.jump_idx     = 26'($urandom);
      s.branch_taken = ($urandom_range(0, 4) == 0);
      s.branch_imm   = 16'($urandom);
      s.call         = ($urandom_range(0, 4) == 0);
      s.ret          = ($urandom_range(0, 6) == 0);
      drive(s, "random");
    end
    drive(idle(), "tail");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
